// File: rtl/shrimp_writeback_if.sv
// shrimp_writeback_if: ALU, load, regfile-write and forwarding signals.
// slave is the arbiter side, master is the producer/consumer side.
interface shrimp_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_val;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_val;
  logic              mem_ready;

  logic              reg_w_enable;
  logic [ADDR_W-1:0] reg_w_addr;
  logic [DATA_W-1:0] reg_w_val;
  logic              squash;

  logic [ADDR_W-1:0] rd_a_addr;
  logic [ADDR_W-1:0] rd_b_addr;
  logic              rd_a_fwd;
  logic              rd_b_fwd;
  logic [DATA_W-1:0] rd_a_fwd_val;
  logic [DATA_W-1:0] rd_b_fwd_val;
  logic              rd_a_pending;
  logic              rd_b_pending;

  modport slave (
    input  alu_valid,
    input  alu_addr,
    input  alu_val,
    input  mem_valid,
    input  mem_addr,
    input  mem_val,
    output mem_ready,
    output reg_w_enable,
    output reg_w_addr,
    output reg_w_val,
    output squash,
    input  rd_a_addr,
    input  rd_b_addr,
    output rd_a_fwd,
    output rd_b_fwd,
    output rd_a_fwd_val,
    output rd_b_fwd_val,
    output rd_a_pending,
    output rd_b_pending
  );

  modport master (
    output alu_valid,
    output alu_addr,
    output alu_val,
    output mem_valid,
    output mem_addr,
    output mem_val,
    input  mem_ready,
    input  reg_w_enable,
    input  reg_w_addr,
    input  reg_w_val,
    input  squash,
    output rd_a_addr,
    output rd_b_addr,
    input  rd_a_fwd,
    input  rd_b_fwd,
    input  rd_a_fwd_val,
    input  rd_b_fwd_val,
    input  rd_a_pending,
    input  rd_b_pending
  );

endinterface

// File: rtl/shrimp_writeback.sv
// shrimp_writeback: ALU/load regfile write arbiter with 2-entry load FIFO.
// Define SHRIMP_WB_FORWARD_EN to enable read forwarding/pending outputs.
module shrimp_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  shrimp_writeback_if.slave bus
);

  logic [1:0]        ent_valid_q;
  logic [1:0]        ent_valid_d;
  logic [ADDR_W-1:0] ent_addr_q [2];
  logic [ADDR_W-1:0] ent_addr_d [2];
  logic [DATA_W-1:0] ent_val_q  [2];
  logic [DATA_W-1:0] ent_val_d  [2];

  logic              head_q;
  logic              head_d;
  logic              tail_q;
  logic              tail_d;
  logic [1:0]        count_q;
  logic [1:0]        count_d;

  logic              w_en_q;
  logic              w_en_d;
  logic [ADDR_W-1:0] w_addr_q;
  logic [ADDR_W-1:0] w_addr_d;
  logic [DATA_W-1:0] w_val_q;
  logic [DATA_W-1:0] w_val_d;
  logic              squash_q;
  logic              squash_d;

  logic              mem_ready;
  logic              accept;
  logic              discard;
  logic              push;
  logic              pop;
  logic              bypass;
  logic [1:0]        hit;

  assign mem_ready = !reset && (count_q < 2'd2);

  always_comb begin
    accept  = bus.mem_valid && mem_ready;
    discard = accept && bus.alu_valid
              && (bus.mem_addr == bus.alu_addr);
    for (int i = 0; i < 2; i++) begin
      hit[i] = bus.alu_valid && ent_valid_q[i]
               && (ent_addr_q[i] == bus.alu_addr);
    end
    pop    = !bus.alu_valid && (count_q != 2'd0);
    bypass = !bus.alu_valid && (count_q == 2'd0) && accept;
    push   = accept && !discard
             && (bus.alu_valid || (count_q != 2'd0));
  end

  always_comb begin
    ent_valid_d = ent_valid_q & ~hit;
    ent_addr_d  = ent_addr_q;
    ent_val_d   = ent_val_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    w_en_d      = 1'b0;
    w_addr_d    = w_addr_q;
    w_val_d     = w_val_q;
    squash_d    = discard || (|hit);

    unique case (1'b1)
      bus.alu_valid: begin
        w_en_d   = 1'b1;
        w_addr_d = bus.alu_addr;
        w_val_d  = bus.alu_val;
      end
      pop: begin
        // A squashed head still costs its slot but produces no write.
        w_en_d              = ent_valid_q[head_q];
        w_addr_d            = ent_addr_q[head_q];
        w_val_d             = ent_val_q[head_q];
        ent_valid_d[head_q] = 1'b0;
        head_d              = ~head_q;
      end
      bypass: begin
        w_en_d   = 1'b1;
        w_addr_d = bus.mem_addr;
        w_val_d  = bus.mem_val;
      end
      default: begin
        w_en_d = 1'b0;
      end
    endcase

    if (push) begin
      ent_valid_d[tail_q] = 1'b1;
      ent_addr_d[tail_q]  = bus.mem_addr;
      ent_val_d[tail_q]   = bus.mem_val;
      tail_d              = ~tail_q;
    end

    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid_q <= '0;
      ent_addr_q  <= '{default: '0};
      ent_val_q   <= '{default: '0};
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= 2'd0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      w_val_q     <= '0;
      squash_q    <= 1'b0;
    end else begin
      ent_valid_q <= ent_valid_d;
      ent_addr_q  <= ent_addr_d;
      ent_val_q   <= ent_val_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      w_val_q     <= w_val_d;
      squash_q    <= squash_d;
    end
  end

  // Gated so nothing commits on the reset edge itself.
  assign bus.mem_ready    = mem_ready;
  assign bus.reg_w_enable = w_en_q && !reset;
  assign bus.reg_w_addr   = reset ? '0 : w_addr_q;
  assign bus.reg_w_val    = reset ? '0 : w_val_q;
  assign bus.squash       = squash_q && !reset;

`ifdef SHRIMP_WB_FORWARD_EN
  logic pend_a;
  logic pend_b;

  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ent_valid_q[i] && ent_addr_q[i] == bus.rd_a_addr)
        pend_a = 1'b1;
      if (ent_valid_q[i] && ent_addr_q[i] == bus.rd_b_addr)
        pend_b = 1'b1;
    end
  end

  assign bus.rd_a_fwd = bus.reg_w_enable
                        && (bus.reg_w_addr == bus.rd_a_addr);
  assign bus.rd_b_fwd = bus.reg_w_enable
                        && (bus.reg_w_addr == bus.rd_b_addr);
  assign bus.rd_a_fwd_val = bus.reg_w_val;
  assign bus.rd_b_fwd_val = bus.reg_w_val;
  assign bus.rd_a_pending = pend_a && !reset;
  assign bus.rd_b_pending = pend_b && !reset;
`else
  logic unused_rd;

  assign unused_rd        = ^{bus.rd_a_addr, bus.rd_b_addr};
  assign bus.rd_a_fwd     = 1'b0;
  assign bus.rd_b_fwd     = 1'b0;
  assign bus.rd_a_fwd_val = '0;
  assign bus.rd_b_fwd_val = '0;
  assign bus.rd_a_pending = 1'b0;
  assign bus.rd_b_pending = 1'b0;
`endif

endmodule

// File: tb/tb_shrimp_writeback.sv
// tb_shrimp_writeback: directed scenarios for the writeback arbiter.
// Forwarding expectations follow SHRIMP_WB_FORWARD_EN.
module tb_shrimp_writeback;

`ifdef SHRIMP_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  shrimp_writeback_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  shrimp_writeback #(.DATA_W(16), .ADDR_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic idle;
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_val   = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_val   = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    step();
    step();
    total++;
    if (bus.reg_w_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_wen got=%b want=0", bus.reg_w_enable);
    end
    total++;
    if (bus.mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b want=0", bus.mem_ready);
    end
    total++;
    if (bus.squash !== 1'b0) begin
      bad++;
      $display("FAIL reset_squash got=%b want=0", bus.squash);
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus.mem_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after got=%b want=1", bus.mem_ready);
    end
    step();
    total++;
    if (bus.reg_w_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_wen_after got=%b want=0", bus.reg_w_enable);
    end
  endtask

  task automatic test_alu_only;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd3;
    bus.alu_val   = 16'h1234;
    step();
    bus.alu_valid = 1'b0;
    total++;
    if ({bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val}
        !== {1'b1, 4'd3, 16'h1234}) begin
      bad++;
      $display("FAIL alu_write got=%b/%h/%h want=1/3/1234",
               bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val);
    end
    step();
    total++;
    if (bus.reg_w_enable !== 1'b0) begin
      bad++;
      $display("FAIL alu_idle got=%b want=0", bus.reg_w_enable);
    end
  endtask

  task automatic test_load_idle;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd5;
    bus.mem_val   = 16'hBEEF;
    #1;
    total++;
    if (bus.mem_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_ready got=%b want=1", bus.mem_ready);
    end
    step();
    bus.mem_valid = 1'b0;
    total++;
    if ({bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val}
        !== {1'b1, 4'd5, 16'hBEEF}) begin
      bad++;
      $display("FAIL load_write got=%b/%h/%h want=1/5/beef",
               bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val);
    end
    step();
    total++;
    if (bus.reg_w_enable !== 1'b0 || bus.mem_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_after got wen=%b rdy=%b want wen=0 rdy=1",
               bus.reg_w_enable, bus.mem_ready);
    end
  endtask

  task automatic test_collision;
    logic       av [7] = '{1, 1, 1, 1, 0, 0, 0};
    logic [3:0] aa [7] = '{1, 2, 3, 4, 0, 0, 0};
    logic       mv [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [3:0] ma [7] = '{8, 9, 10, 10, 10, 10, 0};
    logic       rd [7] = '{1, 1, 0, 0, 0, 1, 1};
    logic [3:0] wa [7] = '{1, 2, 3, 4, 8, 9, 10};
    logic [15:0] wv;
    for (int i = 0; i < 7; i++) begin
      bus.alu_valid = av[i];
      bus.alu_addr  = aa[i];
      bus.alu_val   = {4'h0, aa[i], 4'h0, aa[i]};
      bus.mem_valid = mv[i];
      bus.mem_addr  = ma[i];
      bus.mem_val   = {4'h0, ma[i], 4'h0, ma[i]};
      #1;
      total++;
      if (bus.mem_ready !== rd[i]) begin
        bad++;
        $display("FAIL coll_ready[%0d] got=%b want=%b",
                 i, bus.mem_ready, rd[i]);
      end
      step();
      wv = {4'h0, wa[i], 4'h0, wa[i]};
      total++;
      if ({bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val}
          !== {1'b1, wa[i], wv}) begin
        bad++;
        $display("FAIL coll_write[%0d] got=%b/%h/%h want=1/%h/%h",
                 i, bus.reg_w_enable, bus.reg_w_addr,
                 bus.reg_w_val, wa[i], wv);
      end
    end
    idle();
    step();
    total++;
    if (bus.reg_w_enable !== 1'b0) begin
      bad++;
      $display("FAIL coll_drained got=%b want=0", bus.reg_w_enable);
    end
  endtask

  task automatic test_squash;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd1;
    bus.alu_val   = 16'h1111;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd7;
    bus.mem_val   = 16'hAAAA;
    step();
    bus.alu_addr  = 4'd7;
    bus.alu_val   = 16'h5555;
    bus.mem_valid = 1'b0;
    total++;
    if (bus.squash !== 1'b0) begin
      bad++;
      $display("FAIL sq_early got=%b want=0", bus.squash);
    end
    step();
    idle();
    total++;
    if ({bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val, bus.squash}
        !== {1'b1, 4'd7, 16'h5555, 1'b1}) begin
      bad++;
      $display("FAIL sq_alu got=%b/%h/%h sq=%b want=1/7/5555 sq=1",
               bus.reg_w_enable, bus.reg_w_addr,
               bus.reg_w_val, bus.squash);
    end
    step();
    total++;
    if (bus.reg_w_enable !== 1'b0 || bus.squash !== 1'b0) begin
      bad++;
      $display("FAIL sq_skip got wen=%b sq=%b want 0/0",
               bus.reg_w_enable, bus.squash);
    end
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd5;
    bus.mem_val   = 16'h5A5A;
    step();
    bus.mem_valid = 1'b0;
    total++;
    if ({bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val}
        !== {1'b1, 4'd5, 16'h5A5A}) begin
      bad++;
      $display("FAIL sq_empty got=%b/%h/%h want=1/5/5a5a",
               bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val);
    end
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd9;
    bus.alu_val   = 16'h9999;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd9;
    bus.mem_val   = 16'h1111;
    step();
    idle();
    total++;
    if ({bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val, bus.squash}
        !== {1'b1, 4'd9, 16'h9999, 1'b1}) begin
      bad++;
      $display("FAIL sq_same got=%b/%h/%h sq=%b want=1/9/9999 sq=1",
               bus.reg_w_enable, bus.reg_w_addr,
               bus.reg_w_val, bus.squash);
    end
    step();
    total++;
    if (bus.reg_w_enable !== 1'b0 || bus.squash !== 1'b0) begin
      bad++;
      $display("FAIL sq_same_after got wen=%b sq=%b want 0/0",
               bus.reg_w_enable, bus.squash);
    end
  endtask

  task automatic test_reset_mid;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd1;
    bus.alu_val   = 16'h0001;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd11;
    bus.mem_val   = 16'hBBBB;
    step();
    bus.alu_addr  = 4'd2;
    bus.mem_addr  = 4'd12;
    bus.mem_val   = 16'hCCCC;
    step();
    idle();
    #1;
    total++;
    if (bus.mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL rm_full got=%b want=0", bus.mem_ready);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.reg_w_enable !== 1'b0 || bus.mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL rm_during got wen=%b rdy=%b want 0/0",
               bus.reg_w_enable, bus.mem_ready);
    end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (bus.reg_w_enable !== 1'b0 || bus.mem_ready !== 1'b1) begin
      bad++;
      $display("FAIL rm_release got wen=%b rdy=%b want 0/1",
               bus.reg_w_enable, bus.mem_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.reg_w_enable !== 1'b0) begin
        bad++;
        $display("FAIL rm_stale[%0d] got=%b/%h want=0",
                 i, bus.reg_w_enable, bus.reg_w_addr);
      end
    end
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd3;
    bus.mem_val   = 16'h3333;
    step();
    idle();
    total++;
    if ({bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val}
        !== {1'b1, 4'd3, 16'h3333}) begin
      bad++;
      $display("FAIL rm_bypass got=%b/%h/%h want=1/3/3333",
               bus.reg_w_enable, bus.reg_w_addr, bus.reg_w_val);
    end
    step();
  endtask

  task automatic test_forward;
    bus.rd_a_addr = 4'd2;
    bus.rd_b_addr = 4'd6;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd2;
    bus.alu_val   = 16'h0F0F;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd6;
    bus.mem_val   = 16'h6666;
    step();
    idle();
    total++;
    if ({bus.rd_a_fwd, bus.rd_a_fwd_val}
        !== {FWD, FWD ? 16'h0F0F : 16'h0000}) begin
      bad++;
      $display("FAIL fwd_a got=%b/%h fwd_en=%b",
               bus.rd_a_fwd, bus.rd_a_fwd_val, FWD);
    end
    total++;
    if ({bus.rd_b_fwd, bus.rd_b_pending, bus.rd_a_pending}
        !== {1'b0, FWD, 1'b0}) begin
      bad++;
      $display("FAIL fwd_pend got fwd_b=%b pb=%b pa=%b fwd_en=%b",
               bus.rd_b_fwd, bus.rd_b_pending,
               bus.rd_a_pending, FWD);
    end
    step();
    total++;
    if ({bus.reg_w_enable, bus.reg_w_addr} !== {1'b1, 4'd6}) begin
      bad++;
      $display("FAIL fwd_drain got=%b/%h want=1/6",
               bus.reg_w_enable, bus.reg_w_addr);
    end
    total++;
    if ({bus.rd_b_fwd, bus.rd_b_fwd_val, bus.rd_b_pending,
         bus.rd_a_fwd}
        !== {FWD, FWD ? 16'h6666 : 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL fwd_b got=%b/%h pb=%b fa=%b fwd_en=%b",
               bus.rd_b_fwd, bus.rd_b_fwd_val,
               bus.rd_b_pending, bus.rd_a_fwd, FWD);
    end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.rd_a_addr = '0;
    bus.rd_b_addr = '0;
    idle();
    test_reset();
    test_alu_only();
    test_load_idle();
    test_collision();
    test_squash();
    test_reset_mid();
    test_forward();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
